// File: rtl/mem_arb_rr.sv
// Two-port round-robin arbiter sharing one BRAM request/response port.
// Write bursts lock the grant to their owner; read responses are steered by the mem tag MSB.
module mem_arb_rr #(
    parameter int unsigned DATA_CYCLES = 4,
    parameter int unsigned ADDR_BITS   = 26,
    parameter int unsigned DATA_BITS   = 128,
    parameter int unsigned TAG_BITS    = 5
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  p0_req_val,
    output logic                  p0_req_rdy,
    input  logic                  p0_req_rw,
    input  logic [ADDR_BITS-1:0]  p0_req_addr,
    input  logic [DATA_BITS-1:0]  p0_req_data,
    input  logic [TAG_BITS-2:0]   p0_req_tag,
    output logic                  p0_resp_val,
    output logic [DATA_BITS-1:0]  p0_resp_data,
    output logic [TAG_BITS-2:0]   p0_resp_tag,

    input  logic                  p1_req_val,
    output logic                  p1_req_rdy,
    input  logic                  p1_req_rw,
    input  logic [ADDR_BITS-1:0]  p1_req_addr,
    input  logic [DATA_BITS-1:0]  p1_req_data,
    input  logic [TAG_BITS-2:0]   p1_req_tag,
    output logic                  p1_resp_val,
    output logic [DATA_BITS-1:0]  p1_resp_data,
    output logic [TAG_BITS-2:0]   p1_resp_tag,

    output logic                  mem_req_val,
    input  logic                  mem_req_rdy,
    output logic                  mem_req_rw,
    output logic [ADDR_BITS-1:0]  mem_req_addr,
    output logic [DATA_BITS-1:0]  mem_req_data,
    output logic [TAG_BITS-1:0]   mem_req_tag,

    input  logic                  mem_resp_val,
    input  logic [DATA_BITS-1:0]  mem_resp_data,
    input  logic [TAG_BITS-1:0]   mem_resp_tag
);

    localparam int unsigned CNT_BITS = $clog2(DATA_CYCLES);
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(DATA_CYCLES - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_t;

    lock_t               lock_q, lock_d;
    logic                owner_q, owner_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                prio_q, prio_d;

    logic gnt;
    logic gnt_valid;
    logic sel_val;
    logic accept;

    // Grant selection: a locked burst owns the port even when its val drops.
    always_comb begin
        gnt       = prio_q;
        gnt_valid = 1'b0;
        if (lock_q == LOCKED) begin
            gnt       = owner_q;
            gnt_valid = 1'b1;
        end else if (p0_req_val && p1_req_val) begin
            gnt       = prio_q;
            gnt_valid = 1'b1;
        end else if (p0_req_val) begin
            gnt       = 1'b0;
            gnt_valid = 1'b1;
        end else if (p1_req_val) begin
            gnt       = 1'b1;
            gnt_valid = 1'b1;
        end
    end

    assign sel_val      = gnt ? p1_req_val : p0_req_val;
    assign mem_req_val  = sel_val & gnt_valid & ~reset;
    assign mem_req_rw   = gnt ? p1_req_rw   : p0_req_rw;
    assign mem_req_addr = gnt ? p1_req_addr : p0_req_addr;
    assign mem_req_data = gnt ? p1_req_data : p0_req_data;
    assign mem_req_tag  = {gnt, (gnt ? p1_req_tag : p0_req_tag)};

    assign p0_req_rdy = mem_req_rdy & gnt_valid & ~gnt & ~reset;
    assign p1_req_rdy = mem_req_rdy & gnt_valid &  gnt & ~reset;

    assign accept = mem_req_val & mem_req_rdy;

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        count_d = count_q;
        prio_d  = prio_q;
        if (accept) begin
            if (mem_req_rw) begin
                if (lock_q == UNLOCKED) begin
                    lock_d  = LOCKED;
                    owner_d = gnt;
                    count_d = CNT_BITS'(1);
                end else if (count_q == LAST_BEAT) begin
                    lock_d  = UNLOCKED;
                    count_d = '0;
                    prio_d  = ~gnt;
                end else begin
                    count_d = count_q + CNT_BITS'(1);
                end
            end else if (lock_q == UNLOCKED) begin
                prio_d = ~gnt;
            end
            // A read from the owner mid-burst is forwarded but leaves the lock alone.
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q  <= UNLOCKED;
            owner_q <= 1'b0;
            count_q <= '0;
            prio_q  <= 1'b0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            count_q <= count_d;
            prio_q  <= prio_d;
        end
    end

    assign p0_resp_val  = mem_resp_val & ~mem_resp_tag[TAG_BITS-1];
    assign p1_resp_val  = mem_resp_val &  mem_resp_tag[TAG_BITS-1];
    assign p0_resp_data = mem_resp_data;
    assign p1_resp_data = mem_resp_data;
    assign p0_resp_tag  = mem_resp_tag[TAG_BITS-2:0];
    assign p1_resp_tag  = mem_resp_tag[TAG_BITS-2:0];

endmodule

// File: tb/tb_mem_arb_rr.sv
// Self-checking bench for mem_arb_rr: directed scenarios plus randomized traffic
// compared against a burst/priority reference model.
module tb_mem_arb_rr;

    localparam int unsigned DATA_CYCLES = 4;
    localparam int unsigned ADDR_BITS   = 26;
    localparam int unsigned DATA_BITS   = 128;
    localparam int unsigned TAG_BITS    = 5;

    logic                 clk;
    logic                 reset;
    logic                 p0_req_val, p0_req_rdy, p0_req_rw;
    logic [ADDR_BITS-1:0] p0_req_addr;
    logic [DATA_BITS-1:0] p0_req_data;
    logic [TAG_BITS-2:0]  p0_req_tag;
    logic                 p0_resp_val;
    logic [DATA_BITS-1:0] p0_resp_data;
    logic [TAG_BITS-2:0]  p0_resp_tag;
    logic                 p1_req_val, p1_req_rdy, p1_req_rw;
    logic [ADDR_BITS-1:0] p1_req_addr;
    logic [DATA_BITS-1:0] p1_req_data;
    logic [TAG_BITS-2:0]  p1_req_tag;
    logic                 p1_resp_val;
    logic [DATA_BITS-1:0] p1_resp_data;
    logic [TAG_BITS-2:0]  p1_resp_tag;
    logic                 mem_req_val, mem_req_rdy, mem_req_rw;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic [DATA_BITS-1:0] mem_req_data;
    logic [TAG_BITS-1:0]  mem_req_tag;
    logic                 mem_resp_val;
    logic [DATA_BITS-1:0] mem_resp_data;
    logic [TAG_BITS-1:0]  mem_resp_tag;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: who holds an open write burst, beats taken so far, favoured port.
    int burst_owner = -1;
    int beats_done  = 0;
    int favored     = 0;

    mem_arb_rr #(
        .DATA_CYCLES(DATA_CYCLES),
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS),
        .TAG_BITS(TAG_BITS)
    ) dut (
        .clk(clk), .reset(reset),
        .p0_req_val(p0_req_val), .p0_req_rdy(p0_req_rdy), .p0_req_rw(p0_req_rw),
        .p0_req_addr(p0_req_addr), .p0_req_data(p0_req_data), .p0_req_tag(p0_req_tag),
        .p0_resp_val(p0_resp_val), .p0_resp_data(p0_resp_data), .p0_resp_tag(p0_resp_tag),
        .p1_req_val(p1_req_val), .p1_req_rdy(p1_req_rdy), .p1_req_rw(p1_req_rw),
        .p1_req_addr(p1_req_addr), .p1_req_data(p1_req_data), .p1_req_tag(p1_req_tag),
        .p1_resp_val(p1_resp_val), .p1_resp_data(p1_resp_data), .p1_resp_tag(p1_resp_tag),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic val_of(int p);
        return (p == 1) ? p1_req_val : p0_req_val;
    endfunction

    function automatic logic rw_of(int p);
        return (p == 1) ? p1_req_rw : p0_req_rw;
    endfunction

    function automatic int exp_grant();
        if (burst_owner >= 0) return burst_owner;
        if (p0_req_val && p1_req_val) return favored;
        if (p0_req_val) return 0;
        if (p1_req_val) return 1;
        return -1;
    endfunction

    // Advance the model on the current inputs, then move to 1ns after the next posedge.
    task automatic tick();
        int g;
        g = exp_grant();
        if (reset) begin
            burst_owner = -1;
            beats_done  = 0;
            favored     = 0;
        end else if (g >= 0 && val_of(g) && mem_req_rdy) begin
            if (rw_of(g)) begin
                if (burst_owner < 0) begin
                    burst_owner = g;
                    beats_done  = 1;
                end else begin
                    beats_done = beats_done + 1;
                end
                if (beats_done == DATA_CYCLES) begin
                    burst_owner = -1;
                    beats_done  = 0;
                    favored     = 1 - g;
                end
            end else if (burst_owner < 0) begin
                favored = 1 - g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req_val = 1'b0; p0_req_rw = 1'b0; p0_req_addr = '0; p0_req_data = '0; p0_req_tag = '0;
        p1_req_val = 1'b0; p1_req_rw = 1'b0; p1_req_addr = '0; p1_req_data = '0; p1_req_tag = '0;
        mem_req_rdy = 1'b1;
        mem_resp_val = 1'b0; mem_resp_data = '0; mem_resp_tag = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        p0_req_val = 1'b1; p1_req_val = 1'b1;
        mem_resp_val = 1'b1; mem_resp_tag = 5'h13; mem_resp_data = 128'h1234;
        #1;
        tests_run++;
        if (mem_req_val !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mem_req_val: got %b want 0", mem_req_val);
        end
        tests_run++;
        if ({p0_req_rdy, p1_req_rdy} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_rdy: got %b%b want 00", p0_req_rdy, p1_req_rdy);
        end
        tests_run++;
        if ({p1_resp_val, p0_resp_val, p1_resp_tag} !== 6'b10_0011) begin
            tests_failed++;
            $display("FAIL reset_resp_follow: got p1v=%b p0v=%b tag=%h want 1 0 3", p1_resp_val, p0_resp_val, p1_resp_tag);
        end
        tick();
        tick();
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        logic [DATA_BITS-1:0] d;
        do_reset();
        p0_req_val = 1'b1; p0_req_rw = 1'b0; p0_req_addr = 26'h40; p0_req_tag = 4'h3;
        #1;
        tests_run++;
        if ({mem_req_val, mem_req_tag, mem_req_addr} !== {1'b1, 5'h03, 26'h40}) begin
            tests_failed++;
            $display("FAIL single_read_req: got val=%b tag=%h addr=%h want 1 03 40", mem_req_val, mem_req_tag, mem_req_addr);
        end
        tests_run++;
        if ({p0_req_rdy, p1_req_rdy} !== 2'b10) begin
            tests_failed++; $display("FAIL single_read_rdy: got %b%b want 10", p0_req_rdy, p1_req_rdy);
        end
        tick();
        p0_req_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            mem_resp_val = 1'b1; mem_resp_tag = 5'h03; mem_resp_data = d;
            #1;
            tests_run++;
            if ({p0_resp_val, p1_resp_val, p0_resp_tag} !== 6'b10_0011 || p0_resp_data !== d) begin
                tests_failed++;
                $display("FAIL single_read_resp%0d: got p0v=%b p1v=%b tag=%h data=%h want 1 0 3 %h",
                         i, p0_resp_val, p1_resp_val, p0_resp_tag, p0_resp_data, d);
            end
            tick();
        end
        mem_resp_val = 1'b0;
    endtask

    task automatic test_contended_reads();
        logic [TAG_BITS-1:0] want_tag;
        do_reset();
        p0_req_val = 1'b1; p0_req_rw = 1'b0; p0_req_tag = 4'h2;
        p1_req_val = 1'b1; p1_req_rw = 1'b0; p1_req_tag = 4'h7;
        for (int i = 0; i < 4; i++) begin
            #1;
            want_tag = (i % 2 == 0) ? 5'h02 : 5'h17;
            tests_run++;
            if (mem_req_tag !== want_tag || {p0_req_rdy, p1_req_rdy} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                tests_failed++;
                $display("FAIL contended_read%0d: got tag=%h rdy=%b%b want tag=%h", i, mem_req_tag, p0_req_rdy, p1_req_rdy, want_tag);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_write_lock();
        do_reset();
        p1_req_val = 1'b1; p1_req_rw = 1'b1; p1_req_tag = 4'h5;
        for (int b = 0; b < 4; b++) begin
            p1_req_data = {4{$urandom}};
            if (b >= 1) begin
                p0_req_val = 1'b1; p0_req_rw = 1'b0; p0_req_tag = 4'h1;
            end
            #1;
            tests_run++;
            if ({p0_req_rdy, p1_req_rdy, mem_req_rw, mem_req_tag} !== {3'b011, 5'h15} || mem_req_data !== p1_req_data) begin
                tests_failed++;
                $display("FAIL write_lock_beat%0d: got rdy=%b%b rw=%b tag=%h want 01 1 15", b, p0_req_rdy, p1_req_rdy, mem_req_rw, mem_req_tag);
            end
            tick();
        end
        p1_req_rw = 1'b0;
        #1;
        tests_run++;
        if ({p0_req_rdy, p1_req_rdy, mem_req_tag} !== {2'b10, 5'h01}) begin
            tests_failed++;
            $display("FAIL write_lock_release: got rdy=%b%b tag=%h want 10 01", p0_req_rdy, p1_req_rdy, mem_req_tag);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_owner_drop();
        do_reset();
        p1_req_val = 1'b1; p1_req_rw = 1'b0; p1_req_tag = 4'h9;
        p0_req_rw = 1'b1; p0_req_tag = 4'h4;
        for (int c = 0; c < 6; c++) begin
            p0_req_val = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            #1;
            tests_run++;
            if (p1_req_rdy !== 1'b0 || mem_req_val !== p0_req_val || (p0_req_val && p0_req_rdy !== 1'b1)) begin
                tests_failed++;
                $display("FAIL owner_drop_cycle%0d: got memval=%b rdy=%b%b want memval=%b p1rdy=0",
                         c, mem_req_val, p0_req_rdy, p1_req_rdy, p0_req_val);
            end
            tick();
        end
        p0_req_val = 1'b0;
        #1;
        tests_run++;
        if ({p1_req_rdy, mem_req_tag} !== {1'b1, 5'h19}) begin
            tests_failed++; $display("FAIL owner_drop_release: got p1rdy=%b tag=%h want 1 19", p1_req_rdy, mem_req_tag);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        p1_req_val = 1'b1; p1_req_rw = 1'b1; p1_req_tag = 4'h6;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        p1_req_rw = 1'b0;
        p0_req_val = 1'b1; p0_req_rw = 1'b0; p0_req_tag = 4'hA;
        #1;
        tests_run++;
        if ({p0_req_rdy, p1_req_rdy, mem_req_tag} !== {2'b10, 5'h0A}) begin
            tests_failed++;
            $display("FAIL reset_mid_burst: got rdy=%b%b tag=%h want 10 0a", p0_req_rdy, p1_req_rdy, mem_req_tag);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_rdy_low();
        do_reset();
        p0_req_val = 1'b1; p0_req_rw = 1'b0; p0_req_tag = 4'h2;
        tick();
        p1_req_val = 1'b1; p1_req_rw = 1'b0; p1_req_tag = 4'h3;
        mem_req_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests_run++;
            if ({p0_req_rdy, p1_req_rdy, mem_req_val, mem_req_tag} !== {3'b001, 5'h13}) begin
                tests_failed++;
                $display("FAIL rdy_low_cycle%0d: got rdy=%b%b val=%b tag=%h want 00 1 13", c, p0_req_rdy, p1_req_rdy, mem_req_val, mem_req_tag);
            end
            tick();
        end
        mem_req_rdy = 1'b1;
        #1;
        tests_run++;
        if ({p0_req_rdy, p1_req_rdy} !== 2'b01) begin
            tests_failed++; $display("FAIL rdy_low_release: got rdy=%b%b want 01", p0_req_rdy, p1_req_rdy);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        int g;
        logic [TAG_BITS-1:0] want_tag;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            p0_req_val  = ($urandom_range(0, 99) < 60);
            p1_req_val  = ($urandom_range(0, 99) < 60);
            p0_req_rw   = (burst_owner == 0) ? 1'b1 : 1'($urandom);
            p1_req_rw   = (burst_owner == 1) ? 1'b1 : 1'($urandom);
            p0_req_addr = 26'($urandom); p1_req_addr = 26'($urandom);
            p0_req_data = {4{$urandom}}; p1_req_data = {4{$urandom}};
            p0_req_tag  = 4'($urandom);  p1_req_tag  = 4'($urandom);
            mem_req_rdy = ($urandom_range(0, 99) < 70);
            mem_resp_val  = 1'($urandom);
            mem_resp_tag  = 5'($urandom);
            mem_resp_data = {4{$urandom}};
            #1;
            g = exp_grant();
            tests_run++;
            if (p0_req_rdy !== (g == 0 && mem_req_rdy) || p1_req_rdy !== (g == 1 && mem_req_rdy)) begin
                tests_failed++; $display("FAIL random_rdy c%0d: got %b%b grant=%0d", c, p0_req_rdy, p1_req_rdy, g);
            end
            tests_run++;
            if (mem_req_val !== (g >= 0 && val_of(g))) begin
                tests_failed++; $display("FAIL random_val c%0d: got %b grant=%0d", c, mem_req_val, g);
            end
            if (g >= 0 && val_of(g)) begin
                want_tag = (g == 1) ? {1'b1, p1_req_tag} : {1'b0, p0_req_tag};
                tests_run++;
                if (mem_req_tag !== want_tag || mem_req_addr !== ((g == 1) ? p1_req_addr : p0_req_addr)
                    || mem_req_rw !== rw_of(g)) begin
                    tests_failed++;
                    $display("FAIL random_fields c%0d: got tag=%h addr=%h rw=%b want tag=%h", c, mem_req_tag, mem_req_addr, mem_req_rw, want_tag);
                end
            end
            tests_run++;
            if (p0_resp_val !== (mem_resp_val && !mem_resp_tag[4]) || p1_resp_val !== (mem_resp_val && mem_resp_tag[4])
                || p0_resp_tag !== mem_resp_tag[3:0] || p1_resp_tag !== mem_resp_tag[3:0]) begin
                tests_failed++;
                $display("FAIL random_resp c%0d: got v=%b%b tag=%h want mtag=%h mval=%b", c, p0_resp_val, p1_resp_val, p0_resp_tag, mem_resp_tag, mem_resp_val);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_contended_reads();
        test_write_lock();
        test_owner_drop();
        test_reset_mid_burst();
        test_rdy_low();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_arb_rr.md
# mem_arb_rr

Two-port round-robin arbiter that shares the single BRAM memory port (req/resp, multi-beat data) between two requesters, e.g. core refill path and HTIF. It sits between the requesters and the BRAM memory controller and adds no latency. Write bursts of DATA_CYCLES beats are locked to one owner. Read responses are steered back by a port-ID bit carried in the memory tag.

## Interface
- DATA_CYCLES, 4: beats per transaction (power of two, ≥2)
- ADDR_BITS, 26: memory request address width
- DATA_BITS, 128: beat width
- TAG_BITS, 5: memory-side tag width; requester tags are TAG_BITS-1 wide
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- pN_req_val  input  1  request/write-beat valid, N=0,1
- pN_req_rdy  output  1  request/beat accepted when val&rdy
- pN_req_rw  input  1  1=write beat, 0=read request
- pN_req_addr  input  ADDR_BITS  address
- pN_req_data  input  DATA_BITS  write beat data
- pN_req_tag  input  TAG_BITS-1  requester tag
- pN_resp_val  output  1  read response beat valid
- pN_resp_data  output  DATA_BITS  response beat
- pN_resp_tag  output  TAG_BITS-1  response tag, MSB of mem tag stripped
- mem_req_val  output  1  to memory
- mem_req_rdy  input  1  from memory (low while memory streams a read)
- mem_req_rw, mem_req_addr, mem_req_data  output  1/ADDR_BITS/DATA_BITS  muxed from granted port
- mem_req_tag  output  TAG_BITS  {granted port ID, requester tag}
- mem_resp_val, mem_resp_data, mem_resp_tag  input  1/DATA_BITS/TAG_BITS  from memory

## Operation
- State: lock (1b), owner (1b), beat counter (log2 DATA_CYCLES b), prio (1b, port favoured on contention).
- Unlocked: grant = sole valid port; if both valid, grant = prio. No valid port: no grant, mem_req_val=0.
- Locked: grant = owner regardless of other port; if owner drops val mid-burst, mem_req_val=0 and other port stays blocked.
- Muxed request fields and mem_req_val = granted port's; pN_req_rdy = mem_req_rdy & grant==N & ~reset; the non-granted port sees rdy=0.
- Accepted read (val&rdy&~rw): transaction done; prio <= other port.
- Accepted write beat: first beat sets lock, owner=port, count=1; subsequent beats increment; beat DATA_CYCLES (count==DATA_CYCLES-1 on accept) clears lock, count=0, prio <= other port.
- Read request from owner while locked is a protocol error; arbiter forwards it unchanged, lock state untouched.
- Responses: mem_resp_tag[TAG_BITS-1] selects port; that port's resp_val=mem_resp_val, data/tag forwarded; other port resp_val=0. Every beat of a read burst routed identically.

## Timing
- Fully combinational request and response paths: zero added latency; memory latency as seen by requester unchanged.
- Arbiter state updates at posedge clk only on accepted handshakes.
- Reset: lock=0, owner=0, count=0, prio=port 0; while reset high mem_req_val=0, p0/p1_req_rdy=0; resp outputs still follow mem_resp (resp_val low once memory is reset).
- Reset mid-burst abandons lock; next cycle after deassert arbitrates fresh with port 0 favoured.
- Simultaneous val on both ports same cycle: exactly one rdy, never both.
- mem_req_rdy low: no acceptance, no state change, grant held stable by priority/lock (request fields stay those of the granted port).
- Count wraps to 0 exactly at burst end; never carries into next burst.

## Test plan
- Reset, p0 read addr 0x40 tag 3 only → mem_req_tag=0x03, p0_req_rdy=1; 4 resp beats with tag 0x03 appear on p0 only, p1_resp_val=0.
- Both ports read same cycle after reset → p0 granted first (tag 0x0_), p1 granted on next rdy (tag 0x1_ i.e. 0x10|tag); prio alternates over 4 back-to-back contended reads: 0,1,0,1.
- p1 4-beat write, p0 reads asserted from beat 2 → p0_req_rdy=0 until p1 beat 4 accepted; p0 granted next cycle.
- p0 write drops val for 2 cycles after beat 2 while p1 valid → mem_req_val=0, p1 blocked; beats 3-4 resume for p0.
- Assert reset after beat 2 of p1 write → lock cleared; post-reset p0 and p1 contending → p0 granted.
- mem_req_rdy held low 5 cycles with both valid → no rdy to either port, prio unchanged; on release prio port accepted.
